// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response compactor and the upstream
// pattern-generator stage: FSM state enum and default MISR constants.
package bist_pkg;

  localparam int unsigned DEF_RESP_W = 23;
  localparam int unsigned DEF_SIG_W  = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'h00000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bist_response_compactor_if.sv
// Response-vector stream from the benchmark netlist into the compactor.
//   resp_valid : producer has a vector on resp_data
//   resp_data  : packed outputs N322..N344 (N322 = bit 0)
//   resp_ready : compactor accepts the vector this cycle
interface bist_response_compactor_if #(
  parameter int unsigned RESP_W = bist_pkg::DEF_RESP_W
) ();

  logic              resp_valid;
  logic [RESP_W-1:0] resp_data;
  logic              resp_ready;

  modport master (
    output resp_valid,
    output resp_data,
    input  resp_ready
  );

  modport slave (
    input  resp_valid,
    input  resp_data,
    output resp_ready
  );

endinterface

// File: rtl/misr_step.sv
// One MISR step: shift left, fold the MSB back through POLY, and XOR in
// the zero-extended response vector. Purely combinational.
//   sig_cur    : current signature
//   data       : response vector
//   sig_next_c : next signature
module misr_step
  import bist_pkg::*;
#(
  parameter int unsigned      SIG_W  = DEF_SIG_W,
  parameter int unsigned      RESP_W = DEF_RESP_W,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY)
) (
  input  logic [SIG_W-1:0]  sig_cur,
  input  logic [RESP_W-1:0] data,
  output logic [SIG_W-1:0]  sig_next_c
);

  assign sig_next_c = {sig_cur[SIG_W-2:0], 1'b0}
                    ^ (sig_cur[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(data);

endmodule

// File: rtl/bist_response_compactor.sv
// BIST response compactor: accepts response vectors over a valid/ready
// stream, folds them into a MISR for a programmed number of patterns and
// compares the final signature against a golden value.
//   clk, rst      : clock, synchronous active-high reset
//   start, abort  : run control (abort wins over start and transfers)
//   num_patterns  : patterns per run, latched on start
//   golden_sig    : expected signature, latched on start
//   rif           : response stream (slave side)
//   busy, done    : in RUN / in DONE
//   pass          : signature matched golden (meaningful while done=1)
//   signature     : current MISR contents
//   pat_count     : responses accepted in this run
module bist_response_compactor
  import bist_pkg::*;
#(
  parameter int unsigned      RESP_W = DEF_RESP_W,
  parameter int unsigned      SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
  parameter int unsigned      CNT_W  = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CNT_W-1:0]          num_patterns,
  input  logic [SIG_W-1:0]          golden_sig,
  bist_response_compactor_if.slave  rif,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [SIG_W-1:0]          signature,
  output logic [CNT_W-1:0]          pat_count
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic [SIG_W-1:0] sig_d;
  logic [CNT_W-1:0] cnt_d;
  logic             pass_d;
  logic             ready_q;
  logic             xfer;
  logic             last_xfer;
  logic [SIG_W-1:0] misr_next_c;

  assign rif.resp_ready = ready_q;

  // Next MISR value for the vector currently on the stream
  misr_step #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY)
  ) u_misr (
    .sig_cur    (signature),
    .data       (rif.resp_data),
    .sig_next_c (misr_next_c)
  );

  // Next-state and datapath decode
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    golden_d  = golden_q;
    sig_d     = signature;
    cnt_d     = pat_count;
    pass_d    = pass;
    xfer      = rif.resp_valid & ready_q;
    last_xfer = (pat_count + CNT_W'(1)) == num_q;

    if (abort) begin
      // Signature and count are left visible for debug after an abort
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            num_d    = num_patterns;
            golden_d = golden_sig;
            sig_d    = SEED;
            cnt_d    = '0;
            if (num_patterns == '0) begin
              state_d = S_DONE;
              pass_d  = (SEED == golden_sig);
            end else begin
              state_d = S_RUN;
              pass_d  = 1'b0;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            sig_d = misr_next_c;
            cnt_d = pat_count + CNT_W'(1);
            if (last_xfer) begin
              state_d = S_DONE;
              pass_d  = (misr_next_c == golden_q);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      golden_q  <= '0;
      signature <= SEED;
      pat_count <= '0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      golden_q  <= golden_d;
      signature <= sig_d;
      pat_count <= cnt_d;
      pass      <= pass_d;
      busy      <= (state_d == S_RUN);
      done      <= (state_d == S_DONE);
      ready_q   <= (state_d == S_RUN);
    end
  end

endmodule

// File: tb/tb_bist_response_compactor.sv
module tb_bist_response_compactor;

  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED1 = 32'h00000000;
  localparam logic [31:0] SEED2 = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst, start, start2, abort;
  logic [15:0] num_patterns;
  logic [31:0] golden_sig;

  logic        busy, done, pass;
  logic [31:0] signature;
  logic [15:0] pat_count;
  logic        busy2, done2, pass2;
  logic [31:0] signature2;
  logic [15:0] pat_count2;

  int tests = 0;
  int fails = 0;
  logic [22:0] sent[$];

  always #5 clk = ~clk;

  bist_response_compactor_if rif ();
  bist_response_compactor_if rif2 ();

  bist_response_compactor u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .num_patterns (num_patterns),
    .golden_sig   (golden_sig),
    .rif          (rif),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .pat_count    (pat_count)
  );

  bist_response_compactor #(.SEED(SEED2)) u_dut_seed (
    .clk          (clk),
    .rst          (rst),
    .start        (start2),
    .abort        (abort),
    .num_patterns (num_patterns),
    .golden_sig   (golden_sig),
    .rif          (rif2),
    .busy         (busy2),
    .done         (done2),
    .pass         (pass2),
    .signature    (signature2),
    .pat_count    (pat_count2)
  );

  // Signature as a GF(2) polynomial: seed*x^n + sum d_i*x^(n-1-i), mod x^32+POLY
  function automatic logic [31:0] model_sig(input logic [31:0] seed, input logic [22:0] v[$]);
    logic [127:0] acc;
    int n;
    n = v.size();
    acc = 128'(seed) << n;
    for (int i = 0; i < n; i++) acc = acc ^ (128'(v[i]) << (n - 1 - i));
    for (int b = 127; b >= 32; b--)
      if (acc[b]) acc = acc ^ (128'({1'b1, POLY}) << (b - 32));
    return acc[31:0];
  endfunction

  task automatic do_start(input logic [15:0] n, input logic [31:0] g);
    num_patterns = n;
    golden_sig   = g;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  // Present one vector and wait (bounded) until it is accepted
  task automatic send(input logic [22:0] d);
    int budget;
    budget = 20;
    rif.resp_valid = 1'b1;
    rif.resp_data  = d;
    while (rif.resp_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests++;
    if (rif.resp_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_timeout: resp_ready=%b required 1", rif.resp_ready);
    end else begin
      @(negedge clk);
      sent.push_back(d);
    end
    rif.resp_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [22:0] v[$]);
    foreach (v[i]) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(v[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, pass, rif.resp_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b required 0000", {busy, done, pass, rif.resp_ready});
    end
    tests++;
    if (signature !== SEED1 || pat_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_sig: sig=%h cnt=%0d required %h 0", signature, pat_count, SEED1);
    end
    tests++;
    if (signature2 !== SEED2) begin
      fails++;
      $display("FAIL reset_seed2: sig=%h required %h", signature2, SEED2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    sent.delete();
    do_start(16'd1, 32'h1);
    tests++;
    if (busy !== 1'b1 || rif.resp_ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL single_run: busy=%b ready=%b done=%b required 1 1 0", busy, rif.resp_ready, done);
    end
    send(23'h000001);
    tests++;
    if (signature !== 32'h1 || signature !== model_sig(SEED1, sent)) begin
      fails++;
      $display("FAIL single_sig: got %h required %h", signature, 32'h1);
    end
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || pat_count !== 16'd1 || busy !== 1'b0 || rif.resp_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_done: done=%b pass=%b cnt=%0d busy=%b ready=%b required 1 1 1 0 0",
               done, pass, pat_count, busy, rif.resp_ready);
    end
  endtask

  task automatic test_gap(input logic [31:0] golden, input logic exp_pass);
    sent.delete();
    do_start(16'd2, golden);
    send(23'h000001);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rif.resp_ready !== 1'b1 || pat_count !== 16'd1 || done !== 1'b0) begin
        fails++;
        $display("FAIL gap_stall: ready=%b cnt=%0d done=%b required 1 1 0", rif.resp_ready, pat_count, done);
      end
      @(negedge clk);
    end
    send(23'h000001);
    tests++;
    if (signature !== 32'h3 || signature !== model_sig(SEED1, sent)) begin
      fails++;
      $display("FAIL gap_sig: got %h required %h", signature, 32'h3);
    end
    tests++;
    if (done !== 1'b1 || pass !== exp_pass) begin
      fails++;
      $display("FAIL gap_pass: done=%b pass=%b required 1 %b", done, pass, exp_pass);
    end
  endtask

  task automatic test_seed_msb();
    logic [22:0] v[$];
    v.push_back(23'h0);
    num_patterns   = 16'd1;
    golden_sig     = 32'h04C11DB7;
    start2         = 1'b1;
    @(negedge clk);
    start2         = 1'b0;
    rif2.resp_valid = 1'b1;
    rif2.resp_data  = 23'h0;
    @(negedge clk);
    rif2.resp_valid = 1'b0;
    tests++;
    if (signature2 !== 32'h04C11DB7 || signature2 !== model_sig(SEED2, v)) begin
      fails++;
      $display("FAIL seed_msb_sig: got %h required %h", signature2, 32'h04C11DB7);
    end
    tests++;
    if (done2 !== 1'b1 || pass2 !== 1'b1 || pat_count2 !== 16'd1) begin
      fails++;
      $display("FAIL seed_msb_done: done=%b pass=%b cnt=%0d required 1 1 1", done2, pass2, pat_count2);
    end
  endtask

  task automatic test_zero(input logic [31:0] golden);
    logic seen_ready;
    seen_ready = 1'b0;
    do_start(16'd0, golden);
    tests++;
    if (done !== 1'b1 || signature !== SEED1 || pat_count !== 16'd0 || pass !== (golden == SEED1)) begin
      fails++;
      $display("FAIL zero_done: done=%b sig=%h cnt=%0d pass=%b required 1 %h 0 %b",
               done, signature, pat_count, pass, SEED1, golden == SEED1);
    end
    for (int i = 0; i < 4; i++) begin
      if (rif.resp_ready !== 1'b0) seen_ready = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (seen_ready !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL zero_ready: ready_seen=%b done=%b required 0 1", seen_ready, done);
    end
  endtask

  task automatic test_abort();
    logic [22:0] v[$];
    logic [31:0] g;
    sent.delete();
    do_start(16'd10, 32'h0);
    for (int i = 0; i < 5; i++) send(23'($urandom));
    rif.resp_valid = 1'b1;
    rif.resp_data  = 23'($urandom);
    abort          = 1'b1;
    @(negedge clk);
    abort          = 1'b0;
    rif.resp_valid = 1'b0;
    tests++;
    if (pat_count !== 16'd5 || signature !== model_sig(SEED1, sent)) begin
      fails++;
      $display("FAIL abort_hold: cnt=%0d sig=%h required 5 %h", pat_count, signature, model_sig(SEED1, sent));
    end
    tests++;
    if ({busy, done, pass, rif.resp_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL abort_flags: got %b required 0000", {busy, done, pass, rif.resp_ready});
    end
    for (int i = 0; i < 10; i++) v.push_back(23'($urandom));
    g = model_sig(SEED1, v);
    sent.delete();
    do_start(16'd10, g);
    tests++;
    if (signature !== SEED1 || pat_count !== 16'd0) begin
      fails++;
      $display("FAIL abort_reseed: sig=%h cnt=%0d required %h 0", signature, pat_count, SEED1);
    end
    send_seq(v);
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || pat_count !== 16'd10 || signature !== g) begin
      fails++;
      $display("FAIL abort_rerun: done=%b pass=%b cnt=%0d sig=%h required 1 1 10 %h",
               done, pass, pat_count, signature, g);
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 6; r++) begin
      logic [22:0] v[$];
      logic [31:0] g, exp;
      logic        corrupt;
      int          n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) v.push_back(23'($urandom));
      exp     = model_sig(SEED1, v);
      corrupt = 1'($urandom_range(0, 1));
      g       = corrupt ? (exp ^ (32'h1 << $urandom_range(0, 31))) : exp;
      sent.delete();
      do_start(16'(n), g);
      send_seq(v);
      tests++;
      if (signature !== exp || pat_count !== 16'(n)) begin
        fails++;
        $display("FAIL random_sig run %0d: sig=%h cnt=%0d required %h %0d", r, signature, pat_count, exp, n);
      end
      tests++;
      if (done !== 1'b1 || pass !== !corrupt) begin
        fails++;
        $display("FAIL random_pass run %0d: done=%b pass=%b required 1 %b", r, done, pass, !corrupt);
      end
    end
  endtask

  task automatic test_rst_and_start();
    sent.delete();
    do_start(16'd8, 32'h0);
    for (int i = 0; i < 3; i++) send(23'($urandom));
    num_patterns = 16'd2;
    golden_sig   = 32'hDEADBEEF;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    tests++;
    if (busy !== 1'b1 || pat_count !== 16'd3 || signature !== model_sig(SEED1, sent)) begin
      fails++;
      $display("FAIL start_in_run: busy=%b cnt=%0d sig=%h required 1 3 %h",
               busy, pat_count, signature, model_sig(SEED1, sent));
    end
    for (int i = 0; i < 2; i++) send(23'($urandom));
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || pat_count !== 16'd5) begin
      fails++;
      $display("FAIL start_no_relatch: busy=%b done=%b cnt=%0d required 1 0 5", busy, done, pat_count);
    end
    rst            = 1'b1;
    rif.resp_valid = 1'b1;
    rif.resp_data  = 23'h7FFFFF;
    @(negedge clk);
    rst            = 1'b0;
    rif.resp_valid = 1'b0;
    tests++;
    if ({busy, done, pass, rif.resp_ready} !== 4'b0000 || signature !== SEED1 || pat_count !== 16'd0) begin
      fails++;
      $display("FAIL rst_mid_run: flags=%b sig=%h cnt=%0d required 0000 %h 0",
               {busy, done, pass, rif.resp_ready}, signature, pat_count, SEED1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
    num_patterns = '0; golden_sig = '0;
    rif.resp_valid  = 1'b0; rif.resp_data  = '0;
    rif2.resp_valid = 1'b0; rif2.resp_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_gap(32'h3, 1'b1);
    test_gap(32'h4, 1'b0);
    test_seed_msb();
    test_zero(32'h0);
    test_zero(32'h5);
    test_abort();
    test_random_runs();
    test_rst_and_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
